// File: rtl/simple_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simple_comp_pkg
// Purpose  : Shared types and constants for the simple_comp stimulus driver:
//            FSM state encoding, operand vector record and the vector table.
// Revision : 1.0  initial release
// ============================================================================
package simple_comp_pkg;

    // Width of every operand and of the result/signature path
    localparam int c_DATA_W    = 16;
    // Number of entries held in the vector table
    localparam int c_VEC_DEPTH = 4;

    // Driver FSM states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_APPLY    = 3'd2,
        S_CAPTURE  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // One stimulus vector: operands for a_in / b_in / c_in
    typedef struct packed {
        logic [c_DATA_W-1:0] a;
        logic [c_DATA_W-1:0] b;
        logic [c_DATA_W-1:0] c;
    } vec_t;

    // Stimulus table, index 0 first
    localparam vec_t c_VEC_TABLE [c_VEC_DEPTH] = '{
        '{a: 16'h0000, b: 16'h0000, c: 16'h0000},
        '{a: 16'h0FFF, b: 16'h0FFF, c: 16'h0FFF},
        '{a: 16'h0000, b: 16'h0000, c: 16'h0FFF},
        '{a: 16'h0666, b: 16'h0666, c: 16'h0666}
    };

    // Signature accumulation: plain modulo-2^16 add, carry dropped
    function automatic logic [c_DATA_W-1:0] sig_add(
        input logic [c_DATA_W-1:0] acc,
        input logic [c_DATA_W-1:0] val
    );
        return acc + val;
    endfunction

endpackage : simple_comp_pkg
`default_nettype wire

// File: rtl/simple_comp_vec_rom.sv
`default_nettype none
// ============================================================================
// Module   : simple_comp_vec_rom
// Purpose  : Combinational lookup of the stimulus vector for a given index.
//            Indices beyond the table return an all-zero vector.
// Revision : 1.0  initial release
// ============================================================================
module simple_comp_vec_rom
    import simple_comp_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] i_idx,
    output vec_t             o_vec
);

    // Table lookup; the loop keeps out-of-range indices safe for any IDX_W
    always_comb begin
        o_vec = '0;
        for (int i = 0; i < c_VEC_DEPTH; i++) begin
            if (int'(i_idx) == i) begin
                o_vec = c_VEC_TABLE[i];
            end
        end
    end

endmodule : simple_comp_vec_rom
`default_nettype wire

// File: rtl/simple_comp_driver.sv
`default_nettype none
// ============================================================================
// Module   : simple_comp_driver
// Purpose  : Drives a fixed set of operand vectors into simple_comp, waits for
//            its ready, samples each result a fixed latency after the vector
//            is applied and folds the results into a 16-bit signature.
//            Aborts with error on ready timeout or ready loss mid-run.
// Revision : 1.0  initial release
// ============================================================================
module simple_comp_driver
    import simple_comp_pkg::*;
#(
    parameter  int NUM_VEC     = 4,
    parameter  int HOLD        = 2,
    parameter  int LATENCY     = 1,
    parameter  int RDY_TIMEOUT = 255,
    localparam int IDX_W       = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                start,
    input  logic                dut_rdy,
    input  logic [c_DATA_W-1:0] dut_d_out,
    output logic [c_DATA_W-1:0] a_out,
    output logic [c_DATA_W-1:0] b_out,
    output logic [c_DATA_W-1:0] c_out,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [c_DATA_W-1:0] signature,
    output logic [IDX_W-1:0]    vec_idx
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int TMO_W  = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT + 1) : 1;

    // Last hold cycle of a vector, and the hold cycle in which the result
    // is valid (LATENCY+1 edges after the vector first appears)
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [HOLD_W-1:0] c_CAP_AT    = HOLD_W'(LATENCY);
    localparam logic [TMO_W-1:0]  c_TMO_LAST  = TMO_W'(RDY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  c_IDX_LAST  = IDX_W'(NUM_VEC - 1);
    // With zero latency the very first hold cycle is already the capture one
    localparam state_t            c_FIRST_ST  = (LATENCY == 0) ? S_CAPTURE : S_APPLY;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_vec_idx;
    logic [HOLD_W-1:0]     r_hold;
    logic [HOLD_W-1:0]     w_hold_inc;
    logic [TMO_W-1:0]      r_tmo;
    logic [c_DATA_W-1:0]   r_signature;
    logic                  r_done;
    logic                  r_error;

    logic                  w_run_start;
    logic                  w_abort;
    logic                  w_finish;
    logic                  w_capture;
    logic                  w_vec_step;
    logic                  w_hold_step;
    logic                  w_tmo_step;
    logic                  w_in_hold;
    vec_t                  w_vec;

    assign w_hold_inc = r_hold + 1'b1;

    // Operand table lookup for the vector currently being applied
    simple_comp_vec_rom #(
        .IDX_W (IDX_W)
    ) u_vec_rom (
        .i_idx (r_vec_idx),
        .o_vec (w_vec)
    );

    // State register; reset wins over everything, including a pending start
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and single-cycle datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_run_start = 1'b0;
        w_abort     = 1'b0;
        w_finish    = 1'b0;
        w_capture   = 1'b0;
        w_vec_step  = 1'b0;
        w_hold_step = 1'b0;
        w_tmo_step  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_WAIT_RDY;
                    w_run_start = 1'b1;
                end
            end
            S_WAIT_RDY: begin
                if (dut_rdy) begin
                    w_state_nxt = c_FIRST_ST;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_state_nxt = S_DONE;
                    w_abort     = 1'b1;
                end else begin
                    w_tmo_step  = 1'b1;
                end
            end
            S_APPLY, S_CAPTURE: begin
                if (!dut_rdy) begin
                    // Ready lost: abort without folding in the current result
                    w_state_nxt = S_DONE;
                    w_abort     = 1'b1;
                end else begin
                    w_capture = (r_state == S_CAPTURE);
                    if (r_hold == c_HOLD_LAST) begin
                        if (r_vec_idx == c_IDX_LAST) begin
                            w_state_nxt = S_DONE;
                            w_finish    = 1'b1;
                        end else begin
                            w_state_nxt = c_FIRST_ST;
                            w_vec_step  = 1'b1;
                        end
                    end else begin
                        w_hold_step = 1'b1;
                        w_state_nxt = (w_hold_inc == c_CAP_AT) ? S_CAPTURE : S_APPLY;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Run counters, signature accumulator and completion flags
    always_ff @(posedge clock) begin
        if (rst) begin
            r_vec_idx   <= '0;
            r_hold      <= '0;
            r_tmo       <= '0;
            r_signature <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_run_start) begin
                r_vec_idx   <= '0;
                r_hold      <= '0;
                r_tmo       <= '0;
                r_signature <= '0;
                r_done      <= 1'b0;
                r_error     <= 1'b0;
            end
            if (w_tmo_step) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_hold_step) begin
                r_hold <= w_hold_inc;
            end
            if (w_vec_step) begin
                r_hold    <= '0;
                r_vec_idx <= r_vec_idx + 1'b1;
            end
            if (w_capture) begin
                r_signature <= sig_add(r_signature, dut_d_out);
            end
            if (w_abort) begin
                r_done  <= 1'b1;
                r_error <= 1'b1;
            end
            if (w_finish) begin
                r_done  <= 1'b1;
            end
        end
    end

    // Operands are only driven while a vector is being held
    always_comb begin
        w_in_hold = (r_state == S_APPLY) || (r_state == S_CAPTURE);
        a_out     = w_in_hold ? w_vec.a : '0;
        b_out     = w_in_hold ? w_vec.b : '0;
        c_out     = w_in_hold ? w_vec.c : '0;
        busy      = w_in_hold || (r_state == S_WAIT_RDY);
    end

    assign done      = r_done;
    assign error     = r_error;
    assign signature = r_signature;
    assign vec_idx   = r_vec_idx;

endmodule : simple_comp_driver
`default_nettype wire

// File: tb/tb_simple_comp_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_comp_driver
// Purpose  : Directed self-checking bench for simple_comp_driver with a
//            behavioural simple_comp stand-in (d_out = a^b^c, one cycle late).
// Revision : 1.0  initial release
// ============================================================================
module tb_simple_comp_driver;

    logic        clock;
    logic        rst;
    logic        start;
    logic        dut_rdy;
    logic        model_ff;
    logic [15:0] dut_d_out;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [15:0] c_out;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] signature;
    logic [1:0]  vec_idx;

    int n_checks;
    int n_fail;
    int busy_cnt;

    simple_comp_driver #(
        .NUM_VEC     (4),
        .HOLD        (2),
        .LATENCY     (1),
        .RDY_TIMEOUT (255)
    ) u_dut (
        .clock     (clock),
        .rst       (rst),
        .start     (start),
        .dut_rdy   (dut_rdy),
        .dut_d_out (dut_d_out),
        .a_out     (a_out),
        .b_out     (b_out),
        .c_out     (c_out),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .signature (signature),
        .vec_idx   (vec_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // simple_comp stand-in: registered XOR of the operands, or constant FFFF
    always @(posedge clock) begin
        if (rst) begin
            dut_d_out <= 16'h0000;
        end else begin
            dut_d_out <= model_ff ? 16'hFFFF : (a_out ^ b_out ^ c_out);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, counting cycles with busy high
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            if (busy) busy_cnt++;
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 100) begin
            step(1);
            k++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic nz;
        n_checks = 0;
        n_fail   = 0;
        busy_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dut_rdy  = 1'b0;
        model_ff = 1'b0;
        step(2);

        // Reset state
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_sig",   {16'd0, signature}, 32'h0);
        chk("rst_a",     {16'd0, a_out}, 32'h0);
        chk("rst_idx",   {30'd0, vec_idx}, 32'd0);

        // Normal run: ready from cycle 3 after reset
        rst = 1'b0;
        step(3);
        dut_rdy  = 1'b1;
        busy_cnt = 0;
        start_pulse();
        chk("run_wait_busy", {31'd0, busy}, 32'd1);
        chk("run_wait_a",    {16'd0, a_out}, 32'h0);
        step(1);
        chk("run_v0_idx",    {30'd0, vec_idx}, 32'd0);
        chk("run_v0_c",      {16'd0, c_out}, 32'h0);
        step(2);
        chk("run_v1_idx",    {30'd0, vec_idx}, 32'd1);
        chk("run_v1_a",      {16'd0, a_out}, 32'h0FFF);
        step(2);
        chk("run_v2_idx",    {30'd0, vec_idx}, 32'd2);
        chk("run_v2_a",      {16'd0, a_out}, 32'h0000);
        chk("run_v2_c",      {16'd0, c_out}, 32'h0FFF);
        step(2);
        chk("run_v3_idx",    {30'd0, vec_idx}, 32'd3);
        chk("run_v3_b",      {16'd0, b_out}, 32'h0666);
        step(2);
        chk("run_done",      {31'd0, done},  32'd1);
        chk("run_error",     {31'd0, error}, 32'd0);
        chk("run_busy",      {31'd0, busy},  32'd0);
        chk("run_sig",       {16'd0, signature}, 32'h2664);
        chk("run_a_idle",    {16'd0, a_out}, 32'h0);
        chk("run_busy_cyc",  busy_cnt, 32'd9);

        // Restart from DONE, with a second start while busy
        start_pulse();
        chk("rs_done_clr",   {31'd0, done}, 32'd0);
        chk("rs_busy",       {31'd0, busy}, 32'd1);
        chk("rs_sig_clr",    {16'd0, signature}, 32'h0);
        step(3);
        start_pulse();
        chk("ign_busy",      {31'd0, busy}, 32'd1);
        chk("ign_idx",       {30'd0, vec_idx}, 32'd1);
        wait_done("ign_done");
        chk("ign_sig",       {16'd0, signature}, 32'h2664);
        chk("ign_error",     {31'd0, error}, 32'd0);

        // Ready dropped during vector 2
        start_pulse();
        step(5);
        chk("drop_idx",      {30'd0, vec_idx}, 32'd2);
        dut_rdy = 1'b0;
        step(1);
        chk("drop_done",     {31'd0, done},  32'd1);
        chk("drop_error",    {31'd0, error}, 32'd1);
        chk("drop_busy",     {31'd0, busy},  32'd0);
        chk("drop_sig",      {16'd0, signature}, 32'h0FFF);
        chk("drop_a",        {16'd0, a_out}, 32'h0);
        step(2);
        chk("drop_sig_hold", {16'd0, signature}, 32'h0FFF);

        // Ready never arrives: timeout after 255 waiting cycles
        start_pulse();
        nz = 1'b0;
        for (int i = 0; i < 254; i++) begin
            step(1);
            if ((a_out | b_out | c_out) != 16'h0) nz = 1'b1;
        end
        chk("tmo_busy_pre",  {31'd0, busy}, 32'd1);
        chk("tmo_done_pre",  {31'd0, done}, 32'd0);
        chk("tmo_ops_zero",  {31'd0, nz},   32'd0);
        step(1);
        chk("tmo_done",      {31'd0, done},  32'd1);
        chk("tmo_error",     {31'd0, error}, 32'd1);
        chk("tmo_sig",       {16'd0, signature}, 32'h0);
        chk("tmo_busy",      {31'd0, busy},  32'd0);

        // Reset during vector 1
        dut_rdy = 1'b1;
        start_pulse();
        step(3);
        chk("mrst_pre_idx",  {30'd0, vec_idx}, 32'd1);
        rst = 1'b1;
        step(1);
        chk("mrst_busy",     {31'd0, busy},  32'd0);
        chk("mrst_done",     {31'd0, done},  32'd0);
        chk("mrst_error",    {31'd0, error}, 32'd0);
        chk("mrst_idx",      {30'd0, vec_idx}, 32'd0);
        chk("mrst_a",        {16'd0, a_out}, 32'h0);
        chk("mrst_sig",      {16'd0, signature}, 32'h0);
        // Reset takes precedence over a simultaneous start
        start = 1'b1;
        step(1);
        rst   = 1'b0;
        start = 1'b0;
        step(1);
        chk("rst_prec_busy", {31'd0, busy}, 32'd0);
        start_pulse();
        wait_done("mrst_run_done");
        chk("mrst_run_sig",  {16'd0, signature}, 32'h2664);

        // Constant FFFF results: signature wraps to FFFC
        model_ff = 1'b1;
        start_pulse();
        wait_done("wrap_done");
        chk("wrap_sig",      {16'd0, signature}, 32'hFFFC);
        chk("wrap_error",    {31'd0, error}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_simple_comp_driver
`default_nettype wire

// File: doc/simple_comp_driver.md
SIMPLE_COMP_DRIVER -- requirements
Module: simple_comp_driver

Interface
REQ-001 Parameter NUM_VEC, default 4: number of stimulus vectors applied per run.
REQ-002 Parameter HOLD, default 2: clock cycles each vector is held on a_out/b_out/c_out; legal range is HOLD > LATENCY.
REQ-003 Parameter LATENCY, default 1: cycles from vector apply to valid dut_d_out.
REQ-004 Parameter RDY_TIMEOUT, default 255: maximum cycles to wait for dut_rdy.
REQ-005 clock  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle run request.
REQ-008 dut_rdy  input  1  ready from simple_comp.
REQ-009 dut_d_out  input  16  result from simple_comp.
REQ-010 a_out, b_out, c_out  output  16 each  operands to simple_comp a_in/b_in/c_in.
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  run finished; held until next accepted start.
REQ-013 error  output  1  run aborted (timeout or rdy loss); valid when done=1.
REQ-014 signature  output  16  running sum of captured results.
REQ-015 vec_idx  output  clog2(NUM_VEC)  index of vector currently applied.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_RDY, APPLY, CAPTURE, DONE.
REQ-017 IDLE: start=1 -> WAIT_RDY; signature, vec_idx, error, done cleared the same edge.
REQ-018 WAIT_RDY: dut_rdy=1 -> APPLY with vec_idx=0; after RDY_TIMEOUT cycles without rdy -> DONE with error=1.
REQ-019 APPLY: a/b/c_out SHALL drive vector vec_idx for HOLD cycles; dut_d_out SHALL be sampled exactly LATENCY+1 edges after the vector first appears (CAPTURE cycle).
REQ-020 CAPTURE: signature <= signature + dut_d_out, modulo 2^16 (carry discarded).
REQ-021 After the final HOLD cycle, vec_idx SHALL increment; after vector NUM_VEC-1 the FSM SHALL go to DONE with error=0.
REQ-022 dut_rdy falling in APPLY/CAPTURE SHALL abort to DONE next edge with error=1; signature frozen.
REQ-023 In IDLE, WAIT_RDY and DONE, a/b/c_out SHALL be 16'h0000.
REQ-024 busy=1 exactly in WAIT_RDY, APPLY, CAPTURE.
REQ-025 start while busy SHALL be ignored; start in DONE SHALL behave as in IDLE.
REQ-026 Vector table (a,b,c): 0:(0000,0000,0000) 1:(0FFF,0FFF,0FFF) 2:(0000,0000,0FFF) 3:(0666,0666,0666).

Reset
REQ-027 rst=1 SHALL force IDLE, all outputs 0, timeout counter 0, regardless of state, including mid-run.
REQ-028 rst SHALL take precedence over start in the same cycle.

Structure
REQ-029 Shared package simple_comp_pkg SHALL hold the state enum, vector record type and the vector table constant.
REQ-030 One sub-module simple_comp_vec_rom (combinational index -> {a,b,c}) SHALL hold the table.

Verification
REQ-031 Bench DUT model: d_out = a^b^c, LATENCY 1, rdy=1 from cycle 3 after reset; start pulse -> done=1, error=0, signature=16'h2664, busy high for one wait + 4*HOLD cycles.
REQ-032 rdy held 0 -> after 255 waiting cycles done=1, error=1, signature=0000, a/b/c_out stayed 0000.
REQ-033 rdy dropped during vector 2 -> done next edge, error=1, signature=0FFF.
REQ-034 rst asserted during vector 1 -> next edge all outputs 0, state IDLE; new start then yields signature 2664.
REQ-035 start pulsed again while busy -> ignored, run completes with signature 2664; start in DONE restarts and clears done.
REQ-036 Model d_out = 16'hFFFF constant -> signature 16'hFFFC (wrap-around).
